load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Data-memory access stage downstream of the instruction controller. Consumes the decoded memory controls (write enable, byte/half/word size, unsigned flag), the ALU-computed address and the rs2 store data. Drives a word-wide req/ack data bus with byte enables and lane steering. Returns sign- or zero-extended load data to the register-write mux, and stalls the core until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent waiting for bus_ack before faulting; 0 disables the timeout.

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  load or store present this cycle; held by core until done
req_write  input  1  1 = store, 0 = load (mem_write_enable)
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (bit_half_word_select)
req_unsigned  input  1  zero-extend load result (is_unsigned)
req_addr  input  32  byte address
req_wdata  input  32  store data (rs2)
stall  output  1  freeze PC/regfile
done  output  1  one-cycle completion pulse
fault  output  1  one-cycle pulse with done; access failed
rdata  output  32  extended load data, valid while done=1
bus_req  output  1  bus request
bus_we  output  1  bus write
bus_addr  output  32  word-aligned address
bus_wdata  output  32  lane-steered write data
bus_be  output  4  byte enables
bus_ack  input  1  bus completion; bus_rdata valid same cycle
bus_rdata  input  32  read word

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs 0 (stall, done, fault, rdata, bus_req, bus_we, bus_addr, bus_wdata, bus_be).
- States: IDLE, ACCESS, SECOND (present only with the optional feature), RESP.
- IDLE, when req_valid=1: latch addr, size, unsigned, write and wdata.
  - If the access is misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=11: go to RESP with fault set. No bus request is issued.
  - Otherwise: go to ACCESS.
- ACCESS:
  - bus_req=1; bus_addr={addr[31:2],2'b00}; bus_we=latched write.
  - All bus outputs are held stable until bus_ack.
  - On bus_ack: go to RESP.
- RESP:
  - done=1, stall=0; then return to IDLE.
  - req_valid is not sampled while in RESP, because the core advances on this edge.
- stall = (IDLE && req_valid) || ACCESS || SECOND. Minimum latency is 3 cycles (accept, ack, done).
- bus_be:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- bus_wdata:
  - byte: replicated x4
  - half: replicated x2
  - word: unchanged
- Load result:
  - Shift bus_rdata right by 8*addr[1:0].
  - Byte/half: sign-extend from bit 7/15, or zero-extend if unsigned.
  - Registered into rdata on ack.
  - For stores and faults, rdata=0.
- Timeout: counter increments each ACCESS/SECOND cycle without ack. When it reaches TIMEOUT_CYCLES, drop bus_req and go to RESP with fault=1. The counter clears on accept.
- bus_ack outside ACCESS/SECOND is ignored.
- Bus outputs are 0 whenever not in ACCESS/SECOND.
- rst during ACCESS: bus_req=0 the following cycle, no done pulse, state IDLE.

Optional Feature:
MISALIGNED_SPLIT_EN
- Defined:
  - Misaligned half/word accesses are no longer faults; they split into two transactions.
  - With N = size in bytes and o = addr[1:0]:
    - ACCESS at floor word: be = ((1<<N)-1)<<o truncated to 4 bits; wdata << 8*o.
    - SECOND at floor+4 (wraps mod 2^32): be = ((1<<N)-1) >> (4-o); wdata >> 8*(4-o).
  - Load data = ({second_rdata, first_rdata} >> 8*o), then extended.
  - A timeout in either phase faults.
  - Minimum latency is 4 cycles.
- Undefined: the SECOND state is absent and misaligned accesses fault as above.

Test Plan:
- LW addr 0x100, ack first ACCESS cycle, bus_rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, stall high cycles 0-1, done cycle 2, rdata 0xDEADBEEF, fault 0.
- LB addr 0x103, bus_rdata 0x80FF0000 -> be 1000, rdata 0xFFFFFF80; same with LBU -> 0x00000080.
- SH addr 0x102, wdata 0x1234ABCD -> bus_we 1, be 1100, bus_wdata 0xABCDABCD, rdata 0.
- LW addr 0x101:
  - Macro undefined -> no bus_req, done+fault cycle 1.
  - Macro defined -> 0x100 be 1110 then 0x104 be 0001; with rdata 0x44332211 and 0x88776655 the result is rdata 0x55443322.
- TIMEOUT_CYCLES=4, bus_ack never asserted -> bus_req high exactly 4 cycles, then done+fault, rdata 0.
- rst asserted in ACCESS with ack arriving in the same cycle -> next cycle bus_req 0, stall 0, done 0, all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage. Takes decoded memory controls,
// the ALU address and rs2 store data. It drives a word-wide req/ack bus with
// byte enables and lane steering, and returns extended load data. The core is
// stalled until the access completes.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   req_valid/write/    access request, held by the core until done
//   size/unsigned/
//   addr/wdata
//   stall               freeze PC/regfile while the access is in flight
//   done, fault         one-cycle completion pulse, failure flag with done
//   rdata               extended load data, valid while done=1
//   bus_req/we/addr/    word-aligned bus request, held until bus_ack
//   wdata/be
//   bus_ack, bus_rdata  bus completion and read word (same cycle)
//
// Parameter TIMEOUT_CYCLES: cycles to wait for bus_ack before faulting
// (0 disables the timeout).
// Optional macro MISALIGNED_SPLIT_EN: misaligned half/word accesses are
// split into two bus transactions instead of faulting.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {IDLE, ACCESS, SECOND, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      state;
    logic [31:0] cnt;
    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic        lat_write;
`ifdef MISALIGNED_SPLIT_EN
    logic        lat_split;
    logic [31:0] lat_wdata;
    logic [31:0] first_q;
`endif

    logic        misaligned;
    logic        bad_size;
    logic [3:0]  be_first;
    logic [31:0] wd_first;
    logic [31:0] ld_word;
    logic        timeout_hit;
`ifdef MISALIGNED_SPLIT_EN
    logic [2:0]  sh_second;
    logic [3:0]  be_second;
    logic [31:0] wd_second;
    logic [31:0] ld_split;
`endif

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic        uns
    );
        case (sz)
            2'b00:   extend = {{24{w[7] & ~uns}}, w[7:0]};
            2'b01:   extend = {{16{w[15] & ~uns}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    always_comb begin
        misaligned = (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        bad_size   = (req_size == 2'b11);
        // Truncation of the shifted mask drops lanes that spill
        // into the next word; aligned accesses never spill.
        be_first   = 4'({4'b0000, size_mask(req_size)} << req_addr[1:0]);
        case (req_size)
            2'b00:   wd_first = {4{req_wdata[7:0]}};
            2'b01:   wd_first = {2{req_wdata[15:0]}};
            default: wd_first = req_wdata;
        endcase
`ifdef MISALIGNED_SPLIT_EN
        if (misaligned)
            wd_first = req_wdata << {req_addr[1:0], 3'b000};
        sh_second = 3'd4 - {1'b0, lat_off};
        be_second = 4'({4'b0000, size_mask(lat_size)} >> sh_second);
        wd_second = lat_wdata >> {sh_second, 3'b000};
        ld_split  = 32'({bus_rdata, first_q} >> {lat_off, 3'b000});
`endif
        ld_word     = bus_rdata >> {lat_off, 3'b000};
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
    end

`ifdef MISALIGNED_SPLIT_EN
    assign stall = (state == IDLE && req_valid)
                || state == ACCESS || state == SECOND;
`else
    assign stall = (state == IDLE && req_valid) || state == ACCESS;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_off      <= '0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
            lat_write    <= 1'b0;
            done         <= 1'b0;
            fault        <= 1'b0;
            rdata        <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_be       <= '0;
`ifdef MISALIGNED_SPLIT_EN
            lat_split    <= 1'b0;
            lat_wdata    <= '0;
            first_q      <= '0;
`endif
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt          <= '0;
                        lat_off      <= req_addr[1:0];
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_write    <= req_write;
`ifdef MISALIGNED_SPLIT_EN
                        lat_wdata    <= req_wdata;
                        lat_split    <= misaligned && !bad_size;
                        if (bad_size) begin
`else
                        if (bad_size || misaligned) begin
`endif
                            state <= RESP;
                            done  <= 1'b1;
                            fault <= 1'b1;
                            rdata <= '0;
                        end else begin
                            state     <= ACCESS;
                            bus_req   <= 1'b1;
                            bus_we    <= req_write;
                            bus_addr  <= {req_addr[31:2], 2'b00};
                            bus_be    <= be_first;
                            bus_wdata <= wd_first;
                        end
                    end
                end
                ACCESS: begin
`ifdef MISALIGNED_SPLIT_EN
                    if (bus_ack && lat_split) begin
                        state     <= SECOND;
                        first_q   <= bus_rdata;
                        bus_addr  <= bus_addr + 32'd4;
                        bus_be    <= be_second;
                        bus_wdata <= wd_second;
                    end else
`endif
                    if (bus_ack || timeout_hit) begin
                        state     <= RESP;
                        done      <= 1'b1;
                        fault     <= !bus_ack;
                        rdata     <= (bus_ack && !lat_write)
                                   ? extend(ld_word, lat_size, lat_unsigned)
                                   : 32'd0;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_be    <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`ifdef MISALIGNED_SPLIT_EN
                SECOND: begin
                    if (bus_ack || timeout_hit) begin
                        state     <= RESP;
                        done      <= 1'b1;
                        fault     <= !bus_ack;
                        rdata     <= (bus_ack && !lat_write)
                                   ? extend(ld_split, lat_size, lat_unsigned)
                                   : 32'd0;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_be    <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`endif
                RESP: begin
                    state <= IDLE;
                    rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors for load_store_unit.
// Built with TIMEOUT_CYCLES=4; follows MISALIGNED_SPLIT_EN when defined.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, done, fault;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .fault(fault), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = u; req_addr = a; req_wdata = wd;
        #1;
    endtask

    // Full single-phase access; ack after dly extra wait cycles.
    task automatic run(input string t, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rw,
                       input int dly, input logic [3:0] ebe,
                       input logic [31:0] ewd, input logic [31:0] erd);
        issue(w, sz, u, a, wd);
        chk({t, ".stall0"}, stall, 1);
        chk({t, ".req0"}, bus_req, 0);
        @(negedge clk);
        for (int i = 0; i < dly; i++) begin
            chk({t, ".wait_stall"}, stall, 1);
            chk({t, ".wait_be"}, bus_be, ebe);
            @(negedge clk);
        end
        chk({t, ".req"}, bus_req, 1);
        chk({t, ".we"}, bus_we, w);
        chk({t, ".addr"}, bus_addr, {a[31:2], 2'b00});
        chk({t, ".be"}, bus_be, ebe);
        chk({t, ".wdata"}, bus_wdata, ewd);
        chk({t, ".stall1"}, stall, 1);
        bus_ack = 1'b1; bus_rdata = rw;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        chk({t, ".done"}, done, 1);
        chk({t, ".fault"}, fault, 0);
        chk({t, ".rdata"}, rdata, erd);
        chk({t, ".stall2"}, stall, 0);
        chk({t, ".req_off"}, bus_req, 0);
        req_valid = 1'b0;
        @(negedge clk);
        chk({t, ".done_pulse"}, done, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst.stall", stall, 0);
        chk("rst.done", done, 0);
        chk("rst.fault", fault, 0);
        chk("rst.rdata", rdata, 0);
        chk("rst.req", bus_req, 0);
        chk("rst.we", bus_we, 0);
        chk("rst.addr", bus_addr, 0);
        chk("rst.wdata", bus_wdata, 0);
        chk("rst.be", bus_be, 0);
        rst = 1'b0;
        @(negedge clk);

        // ack while idle must be ignored
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        chk("idle_ack.done", done, 0);
        chk("idle_ack.req", bus_req, 0);

        run("lw", 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0,
            4'b1111, 32'h0, 32'hDEADBEEF);
        run("lb", 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF0000, 0,
            4'b1000, 32'h0, 32'hFFFFFF80);
        run("lbu", 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF0000, 0,
            4'b1000, 32'h0, 32'h00000080);
        run("sh", 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0,
            4'b1100, 32'hABCDABCD, 32'h0);
        run("lh_wait", 0, 2'b01, 0, 32'h202, 32'h0, 32'h8001_0000, 2,
            4'b1100, 32'h0, 32'hFFFF8001);
        run("sb", 1, 2'b00, 0, 32'h301, 32'h000000A5, 32'h0, 1,
            4'b0010, 32'hA5A5A5A5, 32'h0);

        // reserved size faults in every build
        issue(0, 2'b11, 0, 32'h100, 32'h0);
        chk("rsv.stall", stall, 1);
        @(negedge clk);
        chk("rsv.done", done, 1);
        chk("rsv.fault", fault, 1);
        chk("rsv.req", bus_req, 0);
        req_valid = 1'b0;
        @(negedge clk);

`ifdef MISALIGNED_SPLIT_EN
        issue(0, 2'b10, 0, 32'h101, 32'h0);
        @(negedge clk);
        chk("split.addr1", bus_addr, 32'h100);
        chk("split.be1", bus_be, 4'b1110);
        chk("split.req1", bus_req, 1);
        bus_ack = 1'b1; bus_rdata = 32'h44332211;
        @(negedge clk);
        chk("split.addr2", bus_addr, 32'h104);
        chk("split.be2", bus_be, 4'b0001);
        chk("split.req2", bus_req, 1);
        chk("split.stall2", stall, 1);
        bus_rdata = 32'h88776655;
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = '0;
        chk("split.done", done, 1);
        chk("split.fault", fault, 0);
        chk("split.rdata", rdata, 32'h55443322);
        req_valid = 1'b0;
        @(negedge clk);
`else
        issue(0, 2'b10, 0, 32'h101, 32'h0);
        chk("mis.req0", bus_req, 0);
        @(negedge clk);
        chk("mis.done", done, 1);
        chk("mis.fault", fault, 1);
        chk("mis.req", bus_req, 0);
        chk("mis.rdata", rdata, 0);
        req_valid = 1'b0;
        @(negedge clk);
`endif

        // timeout: ack never comes
        issue(0, 2'b10, 0, 32'h200, 32'h0);
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus_req) n++;
            @(negedge clk);
        end
        chk("to.req_cycles", n, 4);
        chk("to.done", done, 1);
        chk("to.fault", fault, 1);
        chk("to.rdata", rdata, 0);
        req_valid = 1'b0;
        @(negedge clk);

        // reset in ACCESS with ack in the same cycle
        issue(0, 2'b10, 0, 32'h300, 32'h0);
        @(negedge clk);
        chk("rsta.req", bus_req, 1);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("rsta.req_off", bus_req, 0);
        chk("rsta.stall", stall, 0);
        chk("rsta.done", done, 0);
        chk("rsta.fault", fault, 0);
        chk("rsta.rdata", rdata, 0);
        chk("rsta.addr", bus_addr, 0);
        chk("rsta.be", bus_be, 0);
        chk("rsta.wdata", bus_wdata, 0);
        rst = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("rsta.idle_done", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
